// File: rtl/alu_control_mc.sv
// alu_control_mc: ALU control decoder with an iterative multiply/divide
// sequencer, HI/LO result registers and a pipeline stall output.
// alu_sel, hilo_rd and illegal are combinational decodes of aluop/funct.
// The sequencer handles MULT/MULTU/DIV/DIVU in WIDTH cycles. Signed
// variants operate on magnitudes, and the signs are fixed up when the
// result is committed.
module alu_control_mc #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid,
   input  logic [2:0]       aluop,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic [3:0]       alu_sel,
   output logic [1:0]       hilo_rd,
   output logic             illegal,
   output logic             md_busy,
   output logic             md_done,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [3:0] SEL_AND  = 4'b0000;
   localparam logic [3:0] SEL_OR   = 4'b0001;
   localparam logic [3:0] SEL_ADD  = 4'b0010;
   localparam logic [3:0] SEL_XOR  = 4'b0011;
   localparam logic [3:0] SEL_NOR  = 4'b0100;
   localparam logic [3:0] SEL_SUB  = 4'b0110;
   localparam logic [3:0] SEL_SLT  = 4'b0111;
   localparam logic [3:0] SEL_SLTU = 4'b1000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // Two's-complement magnitude when the operation is signed and the value is negative
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic            is_signed);
      logic [WIDTH-1:0] r;
      if (is_signed && v[WIDTH-1]) begin
         r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         r = v;
      end
      return r;
   endfunction

   state_t             state_r;
   logic [CW-1:0]      cnt_r;
   logic [1:0]         op_r;        // funct[1:0]: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
   logic               sign_a_r;
   logic               sign_b_r;
   logic [WIDTH-1:0]   a_raw_r;     // src_a as latched, used for divide-by-zero HI
   logic [WIDTH-1:0]   dvsr_r;      // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] work_r;      // {accumulator/remainder, multiplier/dividend->quotient}
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;
   logic               busy_r;
   logic               done_r;

   logic [3:0]         sel_s;
   logic [1:0]         hilo_s;
   logic               undef_s;
   logic               md_op_s;
   logic               mf_op_s;
   logic               issue_signed_s;

   logic [WIDTH:0]     sum_s;
   logic [WIDTH:0]     shifted_s;
   logic [WIDTH:0]     diff_s;
   logic [2*WIDTH-1:0] step_s;
   logic [2*WIDTH-1:0] prod_neg_s;
   logic [WIDTH-1:0]   fin_hi_s;
   logic [WIDTH-1:0]   fin_lo_s;

   // ALU select, HI/LO read and op-class decode from aluop/funct
   always_comb begin
      sel_s   = SEL_ADD;
      hilo_s  = 2'b00;
      undef_s = 1'b0;
      md_op_s = 1'b0;
      mf_op_s = 1'b0;
      case (aluop)
         3'b000: begin
            case (funct)
               6'b100000: sel_s = SEL_ADD;
               6'b100010: sel_s = SEL_SUB;
               6'b100100: sel_s = SEL_AND;
               6'b100101: sel_s = SEL_OR;
               6'b100110: sel_s = SEL_XOR;
               6'b100111: sel_s = SEL_NOR;
               6'b101010: sel_s = SEL_SLT;
               6'b101011: sel_s = SEL_SLTU;
               6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
                  sel_s   = SEL_ADD;
                  md_op_s = 1'b1;
               end
               6'b010000: begin
                  sel_s   = SEL_ADD;
                  hilo_s  = 2'b01;
                  mf_op_s = 1'b1;
               end
               6'b010010: begin
                  sel_s   = SEL_ADD;
                  hilo_s  = 2'b10;
                  mf_op_s = 1'b1;
               end
               default: begin
                  sel_s   = SEL_ADD;
                  undef_s = 1'b1;
               end
            endcase
         end
         3'b001:  sel_s = SEL_ADD;
         3'b010:  sel_s = SEL_SUB;
         3'b011:  sel_s = SEL_AND;
         3'b100:  sel_s = SEL_OR;
         3'b101:  sel_s = SEL_SLT;
         3'b110:  sel_s = SEL_XOR;
         3'b111:  sel_s = SEL_ADD;
         default: sel_s = SEL_ADD;
      endcase
   end

   assign alu_sel        = sel_s;
   assign hilo_rd        = hilo_s;
   assign illegal        = valid & undef_s;
   assign issue_signed_s = ~funct[0];
   assign stall          = valid & ((md_op_s & (state_r != ST_IDLE)) |
                                    (mf_op_s & (state_r == ST_RUN)));

   // One iteration of shift-add multiply or restoring divide
   always_comb begin
      sum_s     = {1'b0, work_r[2*WIDTH-1:WIDTH]};
      shifted_s = {work_r[2*WIDTH-1:WIDTH], work_r[WIDTH-1]};
      diff_s    = shifted_s - {1'b0, dvsr_r};
      step_s    = work_r;
      if (op_r[1]) begin
         if (!diff_s[WIDTH]) begin
            step_s = {diff_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b1};
         end else begin
            step_s = {shifted_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b0};
         end
      end else begin
         if (work_r[0]) begin
            sum_s = {1'b0, work_r[2*WIDTH-1:WIDTH]} + {1'b0, dvsr_r};
         end else begin
            sum_s = {1'b0, work_r[2*WIDTH-1:WIDTH]};
         end
         step_s = {sum_s, work_r[WIDTH-1:1]};
      end
   end

   // Sign fix-up and divide-by-zero override applied to the last iteration
   always_comb begin
      prod_neg_s = ~step_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
      fin_hi_s   = step_s[2*WIDTH-1:WIDTH];
      fin_lo_s   = step_s[WIDTH-1:0];
      case (op_r)
         2'b00: begin
            if (sign_a_r ^ sign_b_r) begin
               fin_hi_s = prod_neg_s[2*WIDTH-1:WIDTH];
               fin_lo_s = prod_neg_s[WIDTH-1:0];
            end else begin
               fin_hi_s = step_s[2*WIDTH-1:WIDTH];
               fin_lo_s = step_s[WIDTH-1:0];
            end
         end
         2'b01: begin
            fin_hi_s = step_s[2*WIDTH-1:WIDTH];
            fin_lo_s = step_s[WIDTH-1:0];
         end
         2'b10: begin
            if (dvsr_r == {WIDTH{1'b0}}) begin
               fin_hi_s = a_raw_r;
               fin_lo_s = {WIDTH{1'b1}};
            end else begin
               if (sign_a_r ^ sign_b_r) begin
                  fin_lo_s = ~step_s[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1};
               end else begin
                  fin_lo_s = step_s[WIDTH-1:0];
               end
               if (sign_a_r) begin
                  fin_hi_s = ~step_s[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1};
               end else begin
                  fin_hi_s = step_s[2*WIDTH-1:WIDTH];
               end
            end
         end
         2'b11: begin
            if (dvsr_r == {WIDTH{1'b0}}) begin
               fin_hi_s = a_raw_r;
               fin_lo_s = {WIDTH{1'b1}};
            end else begin
               fin_hi_s = step_s[2*WIDTH-1:WIDTH];
               fin_lo_s = step_s[WIDTH-1:0];
            end
         end
         default: begin
            fin_hi_s = step_s[2*WIDTH-1:WIDTH];
            fin_lo_s = step_s[WIDTH-1:0];
         end
      endcase
   end

   // Sequencer FSM: operand capture, WIDTH iterations, HI/LO commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         cnt_r    <= {CW{1'b0}};
         op_r     <= 2'b00;
         sign_a_r <= 1'b0;
         sign_b_r <= 1'b0;
         a_raw_r  <= {WIDTH{1'b0}};
         dvsr_r   <= {WIDTH{1'b0}};
         work_r   <= {(2*WIDTH){1'b0}};
         hi_r     <= {WIDTH{1'b0}};
         lo_r     <= {WIDTH{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (valid && md_op_s) begin
                  state_r  <= ST_RUN;
                  busy_r   <= 1'b1;
                  cnt_r    <= CW'(WIDTH - 1);
                  op_r     <= funct[1:0];
                  sign_a_r <= issue_signed_s & src_a[WIDTH-1];
                  sign_b_r <= issue_signed_s & src_b[WIDTH-1];
                  a_raw_r  <= src_a;
                  dvsr_r   <= magnitude(src_b, issue_signed_s);
                  work_r   <= {{WIDTH{1'b0}}, magnitude(src_a, issue_signed_s)};
               end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            ST_RUN: begin
               work_r <= step_s;
               if (cnt_r == {CW{1'b0}}) begin
                  state_r <= ST_DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  hi_r    <= fin_hi_s;
                  lo_r    <= fin_lo_s;
               end else begin
                  cnt_r <= cnt_r - CW'(1);
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign md_busy = busy_r;
   assign md_done = done_r;
   assign hi      = hi_r;
   assign lo      = lo_r;

endmodule

// File: tb/tb_alu_control_mc.sv
// Directed testbench for alu_control_mc at WIDTH = 8.
module tb_alu_control_mc;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         valid;
   logic [2:0]   aluop;
   logic [5:0]   funct;
   logic [W-1:0] src_a;
   logic [W-1:0] src_b;
   logic [3:0]   alu_sel;
   logic [1:0]   hilo_rd;
   logic         illegal;
   logic         md_busy;
   logic         md_done;
   logic         stall;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int checks = 0;
   int errors = 0;

   alu_control_mc #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid   (valid),
      .aluop   (aluop),
      .funct   (funct),
      .src_a   (src_a),
      .src_b   (src_b),
      .alu_sel (alu_sel),
      .hilo_rd (hilo_rd),
      .illegal (illegal),
      .md_busy (md_busy),
      .md_done (md_done),
      .stall   (stall),
      .hi      (hi),
      .lo      (lo)
   );

   // free-running clock, 10 time units
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [5:0] f_tab [16] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                              6'b100110, 6'b100111, 6'b101010, 6'b101011,
                              6'b011000, 6'b011001, 6'b011010, 6'b011011,
                              6'b010000, 6'b010010, 6'b100001, 6'b000000};
   logic [3:0] s_tab [16] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                              4'b0011, 4'b0100, 4'b0111, 4'b1000,
                              4'b0010, 4'b0010, 4'b0010, 4'b0010,
                              4'b0010, 4'b0010, 4'b0010, 4'b0010};
   logic [1:0] h_tab [16] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                              2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
   logic       u_tab [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [3:0] a_tab [8]  = '{4'b0010, 4'b0010, 4'b0110, 4'b0000,
                              4'b0001, 4'b0111, 4'b0011, 4'b0010};

   task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      valid = 1'b1; aluop = 3'b000; funct = f; src_a = a; src_b = b;
      @(negedge clk);
      valid = 1'b0; funct = 6'b100000;
   endtask

   task automatic wait_done(output int n_cyc, output int n_busy);
      n_cyc  = 1;
      n_busy = 0;
      while (md_done !== 1'b1 && n_cyc < 30) begin
         if (md_busy === 1'b1) n_busy++;
         @(negedge clk);
         n_cyc++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; valid = 1'b0; aluop = 3'b000; funct = 6'b100000;
      src_a = 8'h00; src_b = 8'h00;
      repeat (2) @(negedge clk);
      checks++;
      if (hi !== 8'h00 || lo !== 8'h00 || md_busy !== 1'b0 || md_done !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL reset: hi=%h lo=%h busy=%b done=%b stall=%b, want 00 00 0 0 0",
                  hi, lo, md_busy, md_done, stall);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_decode();
      valid = 1'b0; aluop = 3'b000;
      for (int i = 0; i < 16; i++) begin
         funct = f_tab[i]; #1;
         checks++;
         if (alu_sel !== s_tab[i] || hilo_rd !== h_tab[i] || illegal !== 1'b0) begin
            errors++;
            $display("FAIL decode_funct %b: sel=%b hilo=%b ill=%b, want %b %b 0",
                     f_tab[i], alu_sel, hilo_rd, illegal, s_tab[i], h_tab[i]);
         end
      end
      valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (f_tab[i][5:2] != 4'b0110) begin
            funct = f_tab[i]; #1;
            checks++;
            if (illegal !== u_tab[i]) begin
               errors++;
               $display("FAIL illegal_funct %b: ill=%b, want %b", f_tab[i], illegal, u_tab[i]);
            end
         end
      end
      funct = 6'b111111;
      for (int i = 1; i < 8; i++) begin
         aluop = 3'(i); #1;
         checks++;
         if (alu_sel !== a_tab[i] || illegal !== 1'b0) begin
            errors++;
            $display("FAIL decode_aluop %0d: sel=%b ill=%b, want %b 0", i, alu_sel, illegal, a_tab[i]);
         end
      end
      aluop = 3'b000; funct = 6'b111111; valid = 1'b1; #1;
      checks++;
      if (alu_sel !== 4'b0010 || illegal !== 1'b1 || stall !== 1'b0) begin
         errors++;
         $display("FAIL undef_valid: sel=%b ill=%b stall=%b, want 0010 1 0", alu_sel, illegal, stall);
      end
      valid = 1'b0; #1;
      checks++;
      if (alu_sel !== 4'b0010 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL undef_novalid: sel=%b ill=%b, want 0010 0", alu_sel, illegal);
      end
      funct = 6'b100000;
      @(negedge clk);
      checks++;
      if (md_busy !== 1'b0) begin
         errors++;
         $display("FAIL decode_no_issue: busy=%b, want 0", md_busy);
      end
   endtask

   task automatic test_multu();
      int n_cyc, n_busy;
      issue(6'b011001, 8'hFF, 8'hFF);
      wait_done(n_cyc, n_busy);
      checks++;
      if (n_busy != 8) begin
         errors++;
         $display("FAIL multu_busy_cycles: got %0d, want 8", n_busy);
      end
      checks++;
      if (n_cyc != 9) begin
         errors++;
         $display("FAIL multu_done_latency: got %0d, want 9", n_cyc);
      end
      checks++;
      if (hi !== 8'hFE || lo !== 8'h01) begin
         errors++;
         $display("FAIL multu_result: hi=%h lo=%h, want FE 01", hi, lo);
      end
      @(negedge clk);
      checks++;
      if (md_done !== 1'b0 || md_busy !== 1'b0) begin
         errors++;
         $display("FAIL multu_done_pulse: done=%b busy=%b, want 0 0", md_done, md_busy);
      end
   endtask

   task automatic test_signed();
      int n_cyc, n_busy;
      issue(6'b011000, 8'hFD, 8'h05);
      wait_done(n_cyc, n_busy);
      checks++;
      if (hi !== 8'hFF || lo !== 8'hF1) begin
         errors++;
         $display("FAIL mult_neg: hi=%h lo=%h, want FF F1", hi, lo);
      end
      issue(6'b011010, 8'hF9, 8'h02);
      wait_done(n_cyc, n_busy);
      checks++;
      if (hi !== 8'hFF || lo !== 8'hFD) begin
         errors++;
         $display("FAIL div_neg: hi=%h lo=%h, want FF FD", hi, lo);
      end
      issue(6'b011010, 8'h80, 8'hFF);
      wait_done(n_cyc, n_busy);
      checks++;
      if (hi !== 8'h00 || lo !== 8'h80) begin
         errors++;
         $display("FAIL div_overflow: hi=%h lo=%h, want 00 80", hi, lo);
      end
      issue(6'b011011, 8'h64, 8'h07);
      wait_done(n_cyc, n_busy);
      checks++;
      if (hi !== 8'h02 || lo !== 8'h0E) begin
         errors++;
         $display("FAIL divu_basic: hi=%h lo=%h, want 02 0E", hi, lo);
      end
   endtask

   task automatic test_div_zero();
      int n_cyc, n_busy;
      issue(6'b011011, 8'h2A, 8'h00);
      wait_done(n_cyc, n_busy);
      checks++;
      if (n_busy != 8 || n_cyc != 9) begin
         errors++;
         $display("FAIL divu_zero_timing: busy=%0d done_at=%0d, want 8 9", n_busy, n_cyc);
      end
      checks++;
      if (hi !== 8'h2A || lo !== 8'hFF) begin
         errors++;
         $display("FAIL divu_zero_result: hi=%h lo=%h, want 2A FF", hi, lo);
      end
      issue(6'b011010, 8'hF0, 8'h00);
      wait_done(n_cyc, n_busy);
      checks++;
      if (hi !== 8'hF0 || lo !== 8'hFF) begin
         errors++;
         $display("FAIL div_zero_result: hi=%h lo=%h, want F0 FF", hi, lo);
      end
   endtask

   task automatic test_stall();
      int n_cyc, n_busy;
      issue(6'b011001, 8'h05, 8'h07);
      for (int i = 0; i < 8; i++) begin
         valid = 1'b1; aluop = 3'b000; funct = 6'b010010; #1;
         checks++;
         if (stall !== 1'b1 || md_busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_mflo_run %0d: stall=%b busy=%b, want 1 1", i, stall, md_busy);
         end
         @(negedge clk);
      end
      #1;
      checks++;
      if (md_done !== 1'b1 || stall !== 1'b0 || lo !== 8'h23 || hilo_rd !== 2'b10) begin
         errors++;
         $display("FAIL stall_mflo_done: done=%b stall=%b lo=%h hilo=%b, want 1 0 23 10",
                  md_done, stall, lo, hilo_rd);
      end
      funct = 6'b011000; src_a = 8'hFE; src_b = 8'h03; #1;
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL stall_md_in_done: stall=%b, want 1", stall);
      end
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || md_busy !== 1'b0) begin
         errors++;
         $display("FAIL stall_md_in_idle: stall=%b busy=%b, want 0 0", stall, md_busy);
      end
      @(negedge clk);
      valid = 1'b0; funct = 6'b100000;
      checks++;
      if (md_busy !== 1'b1) begin
         errors++;
         $display("FAIL stall_reissue_accept: busy=%b, want 1", md_busy);
      end
      wait_done(n_cyc, n_busy);
      checks++;
      if (hi !== 8'hFF || lo !== 8'hFA || n_busy != 8) begin
         errors++;
         $display("FAIL stall_reissue_result: hi=%h lo=%h busy=%0d, want FF FA 8", hi, lo, n_busy);
      end
   endtask

   task automatic test_reset_mid_run();
      int n_cyc, n_busy;
      issue(6'b011001, 8'hFF, 8'hFF);
      repeat (3) @(negedge clk);
      rst_n = 1'b0; #1;
      checks++;
      if (hi !== 8'h00 || lo !== 8'h00 || md_busy !== 1'b0 || md_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_run: hi=%h lo=%h busy=%b done=%b, want 00 00 0 0",
                  hi, lo, md_busy, md_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      issue(6'b011001, 8'h03, 8'h04);
      wait_done(n_cyc, n_busy);
      checks++;
      if (hi !== 8'h00 || lo !== 8'h0C || n_cyc != 9) begin
         errors++;
         $display("FAIL after_reset_multu: hi=%h lo=%h done_at=%0d, want 00 0C 9", hi, lo, n_cyc);
      end
   endtask

   // test sequence
   initial begin
      test_reset();
      test_decode();
      test_multu();
      test_signed();
      test_div_zero();
      test_stall();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_control_mc.md
Name: alu_control_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle ALU control decoder.
- Combinationally decodes ALUop/funct into a widened 4-bit ALU select.
- Adds an iterative multiply/divide sequencer with HI/LO registers, and a pipeline stall output.
- Sits between the main control unit and the datapath ALU.

Parameters:
- WIDTH, 32, operand/HI/LO width (≥4); also the iteration count of the sequencer.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- valid  input  1  instruction issue strobe for the current aluop/funct
- aluop  input  3  main-control ALU operation class
- funct  input  6  R-type function field
- src_a  input  WIDTH  rs operand
- src_b  input  WIDTH  rt operand
- alu_sel  output  4  ALU select, combinational
- hilo_rd  output  2  01 = mfhi, 10 = mflo, 00 = none; combinational
- illegal  output  1  valid R-type with undefined funct
- md_busy  output  1  sequencer in RUN
- md_done  output  1  one-cycle pulse, result committed
- stall  output  1  hold the issuing pipeline stage
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- alu_sel encoding: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0110 SUB, 0111 SLT, 1000 SLTU.
- aluop decode: 000 → use funct; 001 ADD; 010 SUB; 011 AND; 100 OR; 101 SLT; 110 XOR; 111 ADD.
- funct decode (aluop = 000):
  - 100000 ADD; 100010 SUB; 100100 AND; 100101 OR; 100110 XOR; 100111 NOR; 101010 SLT; 101011 SLTU.
  - 011000 MULT; 011001 MULTU; 011010 DIV; 011011 DIVU.
  - 010000 MFHI; 010010 MFLO.
  - Any other funct: alu_sel = ADD, and illegal = valid.
- alu_sel, hilo_rd and illegal are purely combinational and independent of FSM state.
- MD ops and MFHI/MFLO drive alu_sel = ADD.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on valid & MD op. Operands are latched, and the signed variants take magnitudes and record sign flags.
  - RUN lasts exactly WIDTH cycles, driven by a counter from WIDTH-1 down to 0.
  - RUN → DONE when the counter reaches 0. HI/LO are written on that edge.
  - DONE → IDLE unconditionally after one cycle. md_done = 1 only in DONE.
- Multiply: unsigned shift-add, one multiplier bit per cycle, 2·WIDTH product {HI,LO}. For MULT, the product is negated if the signs differ.
- Divide: restoring, one quotient bit per cycle; LO = quotient, HI = remainder.
  - DIV: quotient sign = sign_a ^ sign_b; remainder sign = sign_a.
  - Most-negative ÷ −1: LO = most-negative, HI = 0. Wraps, no trap.
- Divide by zero: still takes the full WIDTH cycles. Result LO = all ones, HI = src_a as latched.
- md_busy = 1 in RUN only.
- Stall rules:
  - stall = valid & MD op & (state ≠ IDLE).
  - stall = valid & MFHI/MFLO & (state = RUN).
  - In DONE, HI/LO are already valid, so mfhi/mflo do not stall.
- A new MD op is accepted only in IDLE. A stalled op is re-presented by the pipeline.
- Reset, including mid-RUN: state ← IDLE, hi = lo = 0, counter = 0, md_busy = md_done = 0, partial result discarded.
- Latency: issue edge t, RUN t+1..t+WIDTH, HI/LO valid and md_done high in cycle t+WIDTH+1.

Test Plan:
- Decode sweep: every listed aluop/funct pair → expected alu_sel. funct 111111 with valid=1 → alu_sel 0010, illegal=1. Same with valid=0 → illegal=0.
- WIDTH=8, MULTU FF×FF → md_busy for 8 cycles; md_done at cycle 9 after issue; HI=FE, LO=01.
- WIDTH=8, MULT FD(−3)×05 → HI=FF, LO=F1. DIV F9(−7)/02 → LO=FD, HI=FF. DIV 80/FF → LO=80, HI=00.
- WIDTH=8, DIVU 2A/00 → after 8 RUN cycles: LO=FF, HI=2A.
- Stall during RUN:
  - MFLO presented with valid=1 → stall=1 each RUN cycle.
  - In DONE, stall=0 with the new LO visible.
  - Second MULT presented during DONE → stall=1, then accepted in IDLE.
- Assert rst_n low mid-RUN (cycle 4 of 8) → same-cycle hi=lo=0, md_busy=0. After release, a fresh MULTU 03×04 → LO=0C, HI=00.
